// File: rtl/dm_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the MEM stage and the DMA/debug port.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ACK  = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_STARVE_LIMIT = 8;
    localparam int unsigned DEF_CNT_W        = 4;

endpackage

// File: rtl/dm_arbiter_starve_cnt.sv
// Saturating count of cycles a DMA request has been refused by MEM-stage traffic.
module dm_arbiter_starve_cnt #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_hit_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High when an increment in this cycle lands on (or stays at) the limit.
    assign limit_hit_o = (cnt_q >= (LIMIT_C - CNT_W'(1)));

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data memory arbiter: MEM stage always wins, DMA takes idle slots and
// raises hold_req to ask decode for bubbles when it has been starved too long.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pipe_addr,
    input  logic [31:0] pipe_wdata,
    input  logic [3:0]  pipe_be,
    input  logic        pipe_re,
    input  logic        pipe_we,
    output logic [31:0] pipe_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_be,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        hold_req,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata
);

    arb_state_e  state_q, state_d;
    logic        hold_q, hold_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pipe_busy;
    logic        grant;
    logic        cnt_clr, cnt_inc;
    logic        limit_hit;

    assign pipe_busy = pipe_re | pipe_we;
    assign grant     = dma_req & ~pipe_busy & (state_q != ST_ACK);

    assign dm_addr    = grant ? dma_addr  : pipe_addr;
    assign dm_wdata   = grant ? dma_wdata : pipe_wdata;
    assign dm_be      = grant ? dma_be    : pipe_be;
    assign dm_we      = grant ? dma_we    : pipe_we;
    assign pipe_rdata = dm_rdata;

    dm_arbiter_starve_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cnt_clr),
        .inc_i       (cnt_inc),
        .limit_hit_o (limit_hit)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT, ST_HOLD: begin
                if (grant) begin
                    state_d = ST_ACK;
                    cnt_clr = 1'b1;
                    if (!dma_we) begin
                        rdata_d = dm_rdata;
                    end
                end else if (dma_req) begin
                    cnt_inc = 1'b1;
                    if (limit_hit || (state_q == ST_HOLD)) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // hold_req follows HOLD residency one cycle late and never survives into ACK.
        hold_d = (state_q == ST_HOLD) && (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
        end
    end

    assign dma_ack   = (state_q == ST_ACK);
    assign dma_rdata = rdata_q;
    assign hold_req  = hold_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a cycle-level reference.
module tb_dm_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic [3:0]  pipe_be;
    logic        pipe_re, pipe_we;
    logic        dma_req, dma_we, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_be;
    logic        hold_req;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_we;
    logic [3:0]  dm_be;

    always #5 clk = ~clk;

    dm_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_be    (pipe_be),
        .pipe_re    (pipe_re),
        .pipe_we    (pipe_we),
        .pipe_rdata (pipe_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_be     (dma_be),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .hold_req   (hold_req),
        .dm_addr    (dm_addr),
        .dm_we      (dm_we),
        .dm_wdata   (dm_wdata),
        .dm_be      (dm_be),
        .dm_rdata   (dm_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // The physical memory driven only by the DUT's dm port; ref_mem is the expected image.
    logic [31:0] phys_mem [0:255];
    logic [31:0] ref_mem  [0:255];
    logic        load;

    assign dm_rdata = phys_mem[dm_addr[9:2]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) phys_mem[i] <= ref_mem[i];
        end else if (dm_we) begin
            phys_mem[dm_addr[9:2]] <= merge(phys_mem[dm_addr[9:2]], dm_wdata, dm_be);
        end
    end

    int          checks = 0;
    int          errors = 0;
    bit          ack_now;
    bit          dma_done;
    int          denied;
    logic [31:0] exp_rdata;
    bit          last_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A request is eligible unless this is its ack cycle; it is served whenever MEM is idle.
    task automatic check_outputs();
        bit busy, elig, g;
        busy = pipe_re | pipe_we;
        elig = dma_req && !ack_now;
        g    = elig && !busy;
        chk("dm_addr",   dm_addr,          g ? dma_addr  : pipe_addr);
        chk("dm_wdata",  dm_wdata,         g ? dma_wdata : pipe_wdata);
        chk("dm_be",     32'(dm_be),       32'(g ? dma_be : pipe_be));
        chk("dm_we",     32'(dm_we),       32'(g ? dma_we : pipe_we));
        chk("dma_ack",   32'(dma_ack),     32'(ack_now));
        chk("hold_req",  32'(hold_req),    32'(elig && (denied > LIMIT)));
        chk("dma_rdata", dma_rdata,        exp_rdata);
        if (pipe_re) chk("pipe_rdata", pipe_rdata, ref_mem[pipe_addr[9:2]]);
        last_hold = hold_req;
    endtask

    task automatic update_model();
        bit busy, elig, g;
        if (rst) begin
            ack_now   = 1'b0;
            denied    = 0;
            exp_rdata = '0;
            return;
        end
        busy = pipe_re | pipe_we;
        elig = dma_req && !ack_now;
        g    = elig && !busy;
        if (g) begin
            if (dma_we) ref_mem[dma_addr[9:2]] = merge(ref_mem[dma_addr[9:2]], dma_wdata, dma_be);
            else        exp_rdata = ref_mem[dma_addr[9:2]];
            denied   = 0;
            dma_done = 1'b1;
        end else begin
            if (elig && busy) denied++;
            if (pipe_we) ref_mem[pipe_addr[9:2]] = merge(ref_mem[pipe_addr[9:2]], pipe_wdata, pipe_be);
        end
        ack_now = g;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst) check_outputs();
        else      last_hold = 1'b0;
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic set_dma(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = a;
        dma_wdata = wd;
        dma_be    = be;
        dma_done  = 1'b0;
    endtask

    task automatic run_dma(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output int n);
        set_dma(we, a, wd, be);
        n = 0;
        while (!dma_done && n < 200) begin
            cycle();
            n++;
        end
        chk("dma_granted", 32'(dma_done), 32'd1);
        dma_req = 1'b0;
    endtask

    task automatic pipe_idle();
        pipe_re = 1'b0; pipe_we = 1'b0;
        pipe_addr = '0; pipe_wdata = '0; pipe_be = '0;
    endtask

    // Holds MEM busy reading for 20 cycles with a DMA read pending; returns first hold_req cycle.
    task automatic hold_probe(output int rise);
        set_dma(1'b0, 32'h80, 32'h0, 4'hF);
        pipe_re = 1'b1;
        rise = -1;
        for (int i = 0; i < 20; i++) begin
            pipe_addr = $urandom & 32'h3FC;
            cycle();
            if (last_hold && rise < 0) rise = i;
        end
        pipe_idle();
    endtask

    initial begin
        int n, rise;
        int unsigned busy_pct;
        logic [31:0] v;

        rst = 1'b1; load = 1'b1;
        pipe_idle();
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_be = '0;
        ack_now = 1'b0; dma_done = 1'b0; denied = 0; exp_rdata = '0; last_hold = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
        end
        ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        cycle();
        cycle();
        load = 1'b0;
        rst  = 1'b0;
        cycle();
        chk("reset_rdata", dma_rdata, 32'h0);
        chk("reset_hold",  32'(hold_req), 32'd0);

        // 1: DMA read with idle pipe, granted immediately.
        run_dma(1'b0, 32'h100, 32'h0, 4'hF, n);
        chk("t1_latency", n, 1);
        cycle();
        chk("t1_rdata", dma_rdata, 32'hDEADBEEF);
        $display("t1 dma read 0x100 -> %h after %0d cycle(s)", dma_rdata, n);

        // 2: MEM store and DMA store to the same word; MEM first, DMA lands last.
        pipe_we = 1'b1; pipe_addr = 32'h40; pipe_wdata = 32'h11223344; pipe_be = 4'hF;
        set_dma(1'b1, 32'h40, 32'h55, 4'hF);
        cycle();
        pipe_idle();
        run_dma(1'b1, 32'h40, 32'h55, 4'hF, n);
        cycle();
        chk("t2_mem40", phys_mem[32'h40 >> 2], 32'h00000055);
        $display("t2 mem[0x40] = %h", phys_mem[32'h40 >> 2]);

        // 3: starvation raises hold_req nine cycles after the request.
        hold_probe(rise);
        chk("t3_hold_rise", rise, 9);
        run_dma(1'b0, 32'h80, 32'h0, 4'hF, n);
        cycle();
        chk("t3_hold_after_ack", 32'(hold_req), 32'd0);
        $display("t3 hold_req rose at cycle %0d", rise);

        // 4: back-to-back reads with an idle pipe: one access every two cycles.
        for (int k = 0; k < 4; k++) begin
            run_dma(1'b0, $urandom & 32'h3FC, 32'h0, 4'hF, n);
            chk("t4_latency", n, (k == 0) ? 1 : 2);
            $display("t4 req %0d granted after %0d cycle(s)", k, n);
        end
        cycle();

        // 5: reset while waiting drops the request and clears the starvation count.
        set_dma(1'b0, 32'h80, 32'h0, 4'hF);
        pipe_re = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1; dma_req = 1'b0;
        pipe_idle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("t5_rdata", dma_rdata, 32'h0);
        chk("t5_ack",   32'(dma_ack), 32'd0);
        hold_probe(rise);
        chk("t5_hold_rise", rise, 9);
        run_dma(1'b0, 32'h80, 32'h0, 4'hF, n);
        cycle();
        $display("t5 post-reset hold_req rose at cycle %0d", rise);

        // 6: partial MEM store while a DMA write waits.
        pipe_we = 1'b1; pipe_addr = 32'h8; pipe_wdata = 32'h0000AB00; pipe_be = 4'b0010;
        set_dma(1'b1, 32'h0, 32'hFFFFFFFF, 4'hF);
        cycle();
        pipe_idle();
        run_dma(1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, n);
        cycle();
        chk("t6_byte1", 32'(phys_mem[2][15:8]), 32'hAB);
        $display("t6 mem[0x8] = %h", phys_mem[2]);

        // Random traffic with varying MEM load.
        busy_pct = 0;
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) busy_pct = $urandom_range(0, 97);
            if (!dma_req || dma_done) begin
                if ($urandom_range(0, 99) < 60) begin
                    set_dma(1'($urandom_range(0, 1)), $urandom & 32'h3FC, $urandom, 4'($urandom));
                end else begin
                    dma_req = 1'b0;
                end
            end
            if ($urandom_range(0, 99) < busy_pct) begin
                pipe_re = 1'($urandom_range(0, 1));
                pipe_we = ~pipe_re;
            end else begin
                pipe_re = 1'b0;
                pipe_we = 1'b0;
            end
            pipe_addr  = $urandom & 32'h3FC;
            pipe_wdata = $urandom;
            pipe_be    = 4'($urandom);
            cycle();
        end
        dma_req = 1'b0;
        pipe_idle();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
